// File: rtl/tea_iter_engine.sv
// Iterative TEA block cipher engine (encrypt/decrypt) with valid/ready handshakes.
// UNROLL Feistel cycles are evaluated per clock; a block finishes after ROUNDS/UNROLL
// compute clocks plus one clock to publish the result.
module tea_iter_engine #(
  parameter logic [31:0] DELTA  = 32'h9E3779B9,
  parameter int unsigned ROUNDS = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [63:0]  data_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  data_out,
  output logic         busy
);

  localparam int unsigned   Steps   = ROUNDS / UNROLL;
  localparam int unsigned   CntW    = $clog2(Steps + 1);
  // Decrypt starts from the sum reached at the end of encryption.
  localparam logic [31:0]   SumInit = 32'(DELTA * ROUNDS);

  if (ROUNDS < 1 || ROUNDS > 64) begin : g_bad_rounds
    $error("tea_iter_engine: ROUNDS must be in 1..64");
  end
  if (UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_unroll
    $error("tea_iter_engine: ROUNDS must be a non-zero multiple of UNROLL");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     v0_q, v1_q, sum_q;
  logic [31:0]     v0_d, v1_d, sum_d;
  logic [127:0]    key_q;
  logic            mode_q;
  logic            out_valid_q;
  logic [63:0]     data_out_q;
  logic [31:0]     k0, k1, k2, k3;
  logic            accept;

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  // Ready in IDLE, or in DONE when the current result is being consumed this cycle.
  assign in_ready  = rst_n & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

  // UNROLL chained Feistel cycles starting from the current registered state.
  always_comb begin
    v0_d  = v0_q;
    v1_d  = v1_q;
    sum_d = sum_q;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (!mode_q) begin
        sum_d = sum_d + DELTA;
        v0_d  = v0_d + (((v1_d << 4) + k0) ^ (v1_d + sum_d) ^ ((v1_d >> 5) + k1));
        v1_d  = v1_d + (((v0_d << 4) + k2) ^ (v0_d + sum_d) ^ ((v0_d >> 5) + k3));
      end else begin
        v1_d  = v1_d - (((v0_d << 4) + k2) ^ (v0_d + sum_d) ^ ((v0_d >> 5) + k3));
        v0_d  = v0_d - (((v1_d << 4) + k0) ^ (v1_d + sum_d) ^ ((v1_d >> 5) + k1));
        sum_d = sum_d - DELTA;
      end
    end
  end

  // Control FSM and datapath registers; a new acceptance overrides the per-state update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      v0_q        <= '0;
      v1_q        <= '0;
      sum_q       <= '0;
      key_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StRun: begin
          if (cnt_q == CntW'(Steps)) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            data_out_q  <= {v0_q, v1_q};
          end else begin
            v0_q  <= v0_d;
            v1_q  <= v1_d;
            sum_q <= sum_d;
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (accept) begin
        state_q <= StRun;
        cnt_q   <= '0;
        v0_q    <= data_in[63:32];
        v1_q    <= data_in[31:0];
        key_q   <= key;
        mode_q  <= mode;
        sum_q   <= mode ? SumInit : 32'h0;
      end
    end
  end

endmodule

// File: doc/tea_iter_engine.md
TEA_ITER_ENGINE -- requirements
Module: tea_iter_engine

Interface
REQ-001 Parameter DELTA, default 32'h9E3779B9, TEA key-schedule constant.
REQ-002 Parameter ROUNDS, default 32, total Feistel cycles per block; legal range 1..64.
REQ-003 Parameter UNROLL, default 1, Feistel cycles computed per clock; ROUNDS SHALL be an integer multiple of UNROLL (elaboration error otherwise).
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  request present on data_in/key/mode.
REQ-007 in_ready  output  1  engine can accept a request.
REQ-008 mode  input  1  0 = encrypt, 1 = decrypt; sampled at acceptance.
REQ-009 data_in  input  64  block; v0 = [63:32], v1 = [31:0].
REQ-010 key  input  128  k0 = [127:96], k1 = [95:64], k2 = [63:32], k3 = [31:0].
REQ-011 out_valid  output  1  data_out holds a finished result.
REQ-012 out_ready  input  1  consumer accepts data_out.
REQ-013 data_out  output  64  result {v0,v1}.
REQ-014 busy  output  1  high in RUN or DONE.

Function
REQ-015 FSM states IDLE, RUN, DONE; encoded internally, not exported.
REQ-016 in_ready = 1 only in IDLE, or in DONE in the same cycle out_ready = 1 (back-to-back issue).
REQ-017 Acceptance = in_valid && in_ready; on acceptance data_in, key, mode are latched, round counter cleared, state -> RUN.
REQ-018 Encrypt init: sum = 0; each cycle: sum += DELTA; v0 += ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1); v1 += ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3), using updated v0.
REQ-019 Decrypt init: sum = DELTA*ROUNDS mod 2^32 (elaboration constant); each cycle: v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3); v0 -= ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1), using updated v1; then sum -= DELTA.
REQ-020 All arithmetic 32-bit modulo 2^32; shifts logical, zero fill.
REQ-021 In RUN, UNROLL cycles chained combinationally per clock; counter width clog2(ROUNDS/UNROLL + 1); after ROUNDS/UNROLL clocks state -> DONE.
REQ-022 Latency: out_valid rises exactly ROUNDS/UNROLL + 1 clocks after the acceptance edge.
REQ-023 In DONE, out_valid = 1 and data_out stable until out_valid && out_ready; then -> IDLE, or -> RUN if a new request is accepted in that cycle.
REQ-024 data_out SHALL NOT change while out_valid = 1 and out_ready = 0.
REQ-025 in_valid while in RUN or in DONE without out_ready is ignored; latched key/data/mode unaffected by input changes after acceptance.
REQ-026 Key and mode are held per-request; consecutive requests may use different keys/modes with no extra latency.

Reset
REQ-027 rst_n low: state -> IDLE, counter, v0, v1, sum, latched key/mode -> 0, out_valid = 0, data_out = 0, busy = 0, in_ready = 0 while rst_n low.
REQ-028 Reset asserted mid-RUN or in DONE aborts the block; no out_valid after release.
REQ-029 First acceptance possible on the first rising edge after rst_n deasserts (in_ready = 1 in IDLE).

Verification
REQ-030 Defaults, encrypt, key = 0, data_in = 0 -> data_out = 64'h41EA3A0A_94BAA940, out_valid at acceptance+33.
REQ-031 Decrypt, key = 0, data_in = 64'h41EA3A0A_94BAA940 -> data_out = 0; random key/data encrypt then decrypt round-trip returns original for 1000 vectors.
REQ-032 UNROLL = 4, ROUNDS = 32 -> same vectors as REQ-030, out_valid at acceptance+9.
REQ-033 out_ready held 0 for 20 clocks in DONE -> data_out/out_valid stable, in_ready = 0, new in_valid ignored; on out_ready = 1 with in_valid = 1 -> next block accepted same cycle.
REQ-034 rst_n pulsed low at RUN clock 10 -> all outputs 0, no out_valid afterwards until a new request completes.
REQ-035 in_valid toggling with changed data/key during RUN -> result equals that of the originally accepted request.
